// File: rtl/demux1cross4_tdm_if.sv
// Beat-input and channel-output bundle for the 1:4 TDM demultiplexer.
interface demux1cross4_tdm_if #(
  parameter int W = 8
);
  logic [W-1:0] din;
  logic         din_valid;
  logic         sync;
  logic         din_par;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] c;
  logic [W-1:0] d;
  logic [3:0]   out_valid;
  logic         frame_valid;
  logic         sync_err;
  logic         par_err;

  modport master (
    output din, din_valid, sync, din_par,
    input  a, b, c, d, out_valid, frame_valid, sync_err, par_err
  );

  modport slave (
    input  din, din_valid, sync, din_par,
    output a, b, c, d, out_valid, frame_valid, sync_err, par_err
  );
endinterface

// File: rtl/demux1cross4_tdm.sv
// 1:4 time-division demultiplexer: routes framed slots 0..3 to channels a..d.
// Optional even-parity checking on each accepted beat via TDM_DEMUX_PARITY_EN.
module demux1cross4_tdm #(
  parameter int W = 8
) (
  input logic              clk,
  input logic              rst,
  demux1cross4_tdm_if.slave bus
);

  typedef enum logic {HUNT = 1'b0, LOCK = 1'b1} state_t;

  state_t       state_reg, state_next;
  logic [1:0]   slot_reg, slot_next;
  logic         clean_reg, clean_next;
  logic [3:0]   out_valid_reg, out_valid_next;
  logic         frame_valid_reg, frame_valid_next;
  logic         sync_err_reg, sync_err_next;
  logic         par_err_reg, par_err_next;
  logic [3:0]   wr_en;
  logic         accept;
  logic [1:0]   accept_slot;
  logic         beat_par_err;
  logic [W-1:0] ch_reg [4];

`ifdef TDM_DEMUX_PARITY_EN
  assign beat_par_err = ^{bus.din, bus.din_par};
`else
  logic unused_din_par;
  assign unused_din_par = bus.din_par;
  assign beat_par_err   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= HUNT;
      slot_reg        <= 2'd0;
      clean_reg       <= 1'b0;
      out_valid_reg   <= 4'd0;
      frame_valid_reg <= 1'b0;
      sync_err_reg    <= 1'b0;
      par_err_reg     <= 1'b0;
    end else begin
      state_reg       <= state_next;
      slot_reg        <= slot_next;
      clean_reg       <= clean_next;
      out_valid_reg   <= out_valid_next;
      frame_valid_reg <= frame_valid_next;
      sync_err_reg    <= sync_err_next;
      par_err_reg     <= par_err_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    slot_next        = slot_reg;
    clean_next       = clean_reg;
    wr_en            = 4'd0;
    out_valid_next   = 4'd0;
    frame_valid_next = 1'b0;
    sync_err_next    = 1'b0;
    par_err_next     = 1'b0;
    accept           = 1'b0;
    accept_slot      = slot_reg;

    if (bus.din_valid) begin
      unique case (state_reg)
        HUNT: begin
          if (bus.sync) begin
            accept      = 1'b1;
            accept_slot = 2'd0;
            state_next  = LOCK;
          end
        end
        LOCK: begin
          if (bus.sync) begin
            // An early sync abandons the partial frame but resyncs on this beat.
            sync_err_next = (slot_reg != 2'd0);
            accept        = 1'b1;
            accept_slot   = 2'd0;
          end else if (slot_reg == 2'd0) begin
            sync_err_next = 1'b1;
            state_next    = HUNT;
          end else begin
            accept = 1'b1;
          end
        end
        default: state_next = HUNT;
      endcase
    end

    if (accept) begin
      slot_next  = accept_slot + 2'd1;
      clean_next = ((accept_slot == 2'd0) ? 1'b1 : clean_reg) & ~beat_par_err;
      if (beat_par_err) begin
        par_err_next = 1'b1;
      end else begin
        wr_en[accept_slot]          = 1'b1;
        out_valid_next[accept_slot] = 1'b1;
      end
      frame_valid_next = (accept_slot == 2'd3) & clean_reg & ~beat_par_err;
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_ch
    always_ff @(posedge clk) begin
      if (rst) begin
        ch_reg[gi] <= '0;
      end else if (wr_en[gi]) begin
        ch_reg[gi] <= bus.din;
      end
    end
  end

  assign bus.a           = ch_reg[0];
  assign bus.b           = ch_reg[1];
  assign bus.c           = ch_reg[2];
  assign bus.d           = ch_reg[3];
  assign bus.out_valid   = out_valid_reg;
  assign bus.frame_valid = frame_valid_reg;
  assign bus.sync_err    = sync_err_reg;
  assign bus.par_err     = par_err_reg;

endmodule

// File: doc/demux1cross4_tdm.md
# demux1cross4_tdm

Sequential 1-to-4 time-division demultiplexer: the receive-side counterpart to the team's 4:1 channel multiplexer. It takes a framed stream of W-bit beats, where a `sync` flag marks slot 0, and routes slot k to output channel register k (a, b, c, d). Each channel update is strobed, and a pulse marks each complete frame. It sits downstream of the slot multiplexer and recovers the four original channels.

## Interface
- `W`, 8, beat and channel width in bits.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `din`  in  W  beat data.
- `din_valid`  in  1  beat present this cycle.
- `sync`  in  1  beat is slot 0 of a frame; only meaningful with `din_valid`.
- `din_par`  in  1  even-parity bit over `din`; used only with `TDM_DEMUX_PARITY_EN`.
- `a`, `b`, `c`, `d`  out  W  channel hold registers for slots 0, 1, 2, 3.
- `out_valid`  out  4  one-cycle strobe; bit k means channel k was updated.
- `frame_valid`  out  1  one-cycle pulse; slots 0–3 of one frame were received in order.
- `sync_err`  out  1  one-cycle pulse on a framing violation.
- `par_err`  out  1  one-cycle pulse on a parity mismatch; tied to 0 without the macro.

## Operation
- FSM has two states, HUNT and LOCK, and a 2-bit slot counter `slot`.
- HUNT:
  - Beats with `sync=0` are discarded silently.
  - A beat with `sync=1` writes `a`, sets `slot=1` and moves to LOCK.
- LOCK, beat with `sync=0` and `slot≠0`:
  - Write channel `slot`; `slot` increments modulo 4.
  - Writing slot 3 wraps `slot` to 0 and asserts `frame_valid` in the same cycle as `out_valid[3]`, provided the frame is clean.
- LOCK, beat with `sync=1` and `slot=0`: normal frame start. Write `a`, `slot=1`.
- LOCK, beat with `sync=1` and `slot≠0` (early sync):
  - Pulse `sync_err` and abandon the partial frame; no `frame_valid` for it.
  - Resync immediately: write `a`, `slot=1`, stay in LOCK.
- LOCK, beat with `sync=0` and `slot=0` (missing sync): pulse `sync_err`, drop the beat, go to HUNT.
- Cycles with `din_valid=0` change nothing; `sync` is ignored on those cycles.
- A channel register changes only when its own slot is written. Otherwise it holds its value indefinitely.
- A frame is clean when its four slots were written consecutively in LOCK with no error in between.

## Timing
- All outputs are registered.
- Channel data and `out_valid[k]` appear on the cycle after the accepting edge, so latency is 1 cycle.
- Sustained throughput is one beat per cycle. There is no backpressure; every valid beat is consumed.
- `out_valid`, `frame_valid`, `sync_err` and `par_err` are single-cycle pulses. They are never stretched, even across back-to-back beats.
- At most one bit of `out_valid` is set in any cycle.
- Reset (`rst=1` at a rising edge):
  - `a`, `b`, `c`, `d` = 0; `out_valid` = 0; all pulse outputs = 0.
  - FSM goes to HUNT with `slot` = 0.
  - Reset overrides a beat presented in the same cycle.
- Reset mid-frame discards the partial frame. The next frame is accepted only after a `sync` beat.

## Configuration
- Macro: `TDM_DEMUX_PARITY_EN`.
- When defined, each accepted beat is checked with `^{din,din_par}` (even parity). On mismatch:
  - `par_err` pulses and the channel register is not written; `out_valid[slot]` stays 0.
  - `slot` still advances normally and FSM state is unchanged.
  - The current frame is marked unclean, so no `frame_valid` at slot 3.
- When undefined:
  - `din_par` is unused and `par_err` is a constant 0.
  - Every accepted beat is written regardless of `din_par`.

## Test plan
- Reset, then one frame with `sync` on 0x11, followed by 0x22, 0x33, 0x44 on consecutive cycles:
  - `a`/`b`/`c`/`d` = 11/22/33/44.
  - `out_valid` reads 0001, 0010, 0100, 1000 on successive cycles.
  - `frame_valid` pulses with `out_valid`=1000.
- Beats 0x55 and 0x66 with `sync=0` straight after reset: no output change, no `sync_err`, FSM stays in HUNT.
- Early sync: frame start 0xA0, then 0xA1, then 0xB0 with `sync=1`:
  - `sync_err` pulses once and `a`=B0.
  - The next three beats complete the frame and `frame_valid` pulses.
- Missing sync: after a clean frame, beat 0x77 with `sync=0`:
  - `sync_err` pulses, nothing is written, FSM returns to HUNT.
  - The following `sync` beat 0x88 sets `a`=88.
- `rst` asserted after slot 1 of a frame: all outputs go to 0. Slots 2–3 that follow without `sync` are ignored.
- With the macro defined, slot 2 = 0x03 with `din_par=1`:
  - `par_err` pulses and `c` keeps its prior value.
  - Slot 3 still writes `d`, but there is no `frame_valid` for that frame.
